// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity selection codes
// and the default oversampling ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE        = 0;
  localparam int PARITY_EVEN        = 1;
  localparam int PARITY_ODD         = 2;
  localparam int OVERSAMPLE_DEFAULT = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from the TX FIFO and serialises them as
// start / DATA_WIDTH data bits LSB first / optional parity / stop period.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int SB_TICK    = 16,
  parameter int PARITY     = PARITY_NONE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_tick,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int TICK_MAX = max_int(OVERSAMPLE, SB_TICK);
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  tx_busy_q, tx_busy_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      tx_busy_q <= tx_busy_d;
    end
  end

  // tx_d carries the level of the bit being entered, so the line changes on
  // the same edge as the state/bit transition.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tx_d         = tx_q;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // reset_n gate keeps the pop strobe quiet while reset is held.
        if (reset_n && !fifo_empty) begin
          fifo_rd = 1'b1;
          shift_d = fifo_r_data;
          par_d   = (PARITY == PARITY_ODD) ? ~^fifo_r_data : ^fifo_r_data;
          tick_d  = '0;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            idx_d   = '0;
            tx_d    = shift_q[0];
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (idx_q == IDX_LAST) begin
              if (PARITY != PARITY_NONE) begin
                tx_d    = par_q;
                state_d = ST_PARITY;
              end else begin
                tx_d    = 1'b1;
                state_d = ST_STOP;
              end
            end else begin
              idx_d = idx_q + IDX_ONE;
              tx_d  = shift_d[0];
            end
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (tick_q == SB_LAST) begin
            tick_d       = '0;
            tx_done_tick = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    tx_busy_d = (state_d != ST_IDLE);
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader: four parameter variants share one
// FIFO model, and sel chooses which instance sees the FIFO as non-empty.
module tb_uart_tx_fifo_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cyc = '0;
  logic        s_tick;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign s_tick = (cyc[1:0] == 2'd0);

  logic [7:0]  mem [0:15];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic        fifo_empty;
  logic [7:0]  head;
  logic [1:0]  sel = 2'd0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign head       = mem[rd_ptr % 16];

  logic [3:0] emp_i, rd_i, tx_i, busy_i, done_i;
  logic       pop, tx_s, busy_s, done_s;

  assign emp_i[0] = fifo_empty || (sel != 2'd0);
  assign emp_i[1] = fifo_empty || (sel != 2'd1);
  assign emp_i[2] = fifo_empty || (sel != 2'd2);
  assign emp_i[3] = fifo_empty || (sel != 2'd3);
  assign pop    = rd_i[sel];
  assign tx_s   = tx_i[sel];
  assign busy_s = busy_i[sel];
  assign done_s = done_i[sel];

  int pop_cnt  = 0;
  int done_cnt = 0;
  int bad_rd   = 0;

  always @(posedge clk) begin
    if (pop) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
    if (done_s) done_cnt <= done_cnt + 1;
    if ((rd_i & emp_i) != 4'b0) bad_rd <= bad_rd + 1;
  end

  uart_tx_fifo_reader #(.DATA_WIDTH(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY(0)) u_none (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .fifo_empty(emp_i[0]),
    .fifo_r_data(head), .fifo_rd(rd_i[0]), .tx(tx_i[0]), .tx_busy(busy_i[0]),
    .tx_done_tick(done_i[0]));

  uart_tx_fifo_reader #(.DATA_WIDTH(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY(1)) u_even (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .fifo_empty(emp_i[1]),
    .fifo_r_data(head), .fifo_rd(rd_i[1]), .tx(tx_i[1]), .tx_busy(busy_i[1]),
    .tx_done_tick(done_i[1]));

  uart_tx_fifo_reader #(.DATA_WIDTH(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY(2)) u_odd (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .fifo_empty(emp_i[2]),
    .fifo_r_data(head), .fifo_rd(rd_i[2]), .tx(tx_i[2]), .tx_busy(busy_i[2]),
    .tx_done_tick(done_i[2]));

  uart_tx_fifo_reader #(.DATA_WIDTH(8), .OVERSAMPLE(16), .SB_TICK(32), .PARITY(0)) u_sb32 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .fifo_empty(emp_i[3]),
    .fifo_r_data(head), .fifo_rd(rd_i[3]), .tx(tx_i[3]), .tx_busy(busy_i[3]),
    .tx_done_tick(done_i[3]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Load on a negedge whose cycle carries s_tick, so the pop cycle is
  // tick-aligned and every bit (start included) is exactly 64 clk.
  task automatic load_aligned(input logic [7:0] b);
    @(negedge clk);
    while (cyc[1:0] != 2'd0) @(negedge clk);
    push(b);
  endtask

  // Records start-bit-relative mid-bit samples (offset 64k+32 from the first
  // low cycle), the fall, last rise and done-tick cycles of one frame.
  task automatic capture_frame(input int nbits, output logic [15:0] bits,
                               output int fall_c, output int done_c,
                               output int rise_c, output bit ok);
    int   idx;
    int   waited;
    logic prev;
    bits = '0; ok = 1'b0; fall_c = 0; done_c = 0; rise_c = 0; idx = 0; waited = 0;
    @(negedge clk);
    while (tx_s !== 1'b0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (tx_s !== 1'b0) return;
    fall_c = int'(cyc);
    prev   = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (tx_s === 1'b1 && prev === 1'b0) rise_c = int'(cyc);
      prev = tx_s;
      if (((int'(cyc) - fall_c) % 64) == 32 && idx < nbits) begin
        bits[idx] = tx_s;
        idx++;
      end
      if (done_s === 1'b1) begin
        done_c = int'(cyc);
        ok     = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int p0;
    sel = 2'd0;
    reset_n = 1'b0;
    push(8'h81);
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (tx_i !== 4'b1111) begin n_bad++; $display("FAIL reset_tx got=%b exp=1111", tx_i); end
    n_cmp++; if (rd_i !== 4'b0000) begin n_bad++; $display("FAIL reset_fifo_rd got=%b exp=0000", rd_i); end
    n_cmp++; if (busy_i !== 4'b0000) begin n_bad++; $display("FAIL reset_busy got=%b exp=0000", busy_i); end
    n_cmp++; if (done_i !== 4'b0000) begin n_bad++; $display("FAIL reset_done got=%b exp=0000", done_i); end
    @(negedge clk);
    p0 = pop_cnt;
    reset_n = 1'b1;
    #1;
    n_cmp++; if (rd_i[0] !== 1'b1) begin n_bad++; $display("FAIL release_fifo_rd got=%b exp=1", rd_i[0]); end
    n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL release_tx_idle got=%b exp=1", tx_s); end
    @(negedge clk);
    n_cmp++; if (rd_i[0] !== 1'b0) begin n_bad++; $display("FAIL release_rd_pulse got=%b exp=0", rd_i[0]); end
    n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL release_tx_fall got=%b exp=0", tx_s); end
    n_cmp++; if (busy_s !== 1'b1) begin n_bad++; $display("FAIL release_busy got=%b exp=1", busy_s); end
    for (int n = 0; n < 1000 && done_s !== 1'b1; n++) @(negedge clk);
    n_cmp++; if (done_s !== 1'b1) begin n_bad++; $display("FAIL release_frame_end got=%b exp=1 (timeout)", done_s); end
    n_cmp++; if (busy_s !== 1'b1) begin n_bad++; $display("FAIL busy_at_done got=%b exp=1", busy_s); end
    @(negedge clk);
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL busy_after_done got=%b exp=0", busy_s); end
    n_cmp++; if (pop_cnt - p0 !== 1) begin n_bad++; $display("FAIL release_pops got=%0d exp=1", pop_cnt - p0); end
  endtask

  task automatic test_frame_a5;
    logic [15:0] bits;
    int f, d, r, p0, d0;
    bit ok;
    sel = 2'd0;
    p0 = pop_cnt; d0 = done_cnt;
    load_aligned(8'hA5);
    capture_frame(10, bits, f, d, r, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL a5_complete got=timeout exp=done"); end
    n_cmp++; if (bits[9:0] !== 10'h34A) begin n_bad++; $display("FAIL a5_bits got=%h exp=34a", bits[9:0]); end
    n_cmp++; if (d - f + 1 !== 640) begin n_bad++; $display("FAIL a5_length got=%0d exp=640", d - f + 1); end
    repeat (100) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL a5_done_count got=%0d exp=1", done_cnt - d0); end
    n_cmp++; if (pop_cnt - p0 !== 1) begin n_bad++; $display("FAIL a5_pops got=%0d exp=1", pop_cnt - p0); end
    n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL a5_idle_tx got=%b exp=1", tx_s); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] b1, b2, b3;
    int f1, d1, r1, f2, d2, r2, f3, d3, r3, p0;
    bit ok1, ok2, ok3;
    sel = 2'd0;
    p0 = pop_cnt;
    @(negedge clk);
    while (cyc[1:0] != 2'd0) @(negedge clk);
    push(8'h55); push(8'h0F); push(8'hFF);
    capture_frame(10, b1, f1, d1, r1, ok1);
    capture_frame(10, b2, f2, d2, r2, ok2);
    capture_frame(10, b3, f3, d3, r3, ok3);
    n_cmp++; if (!(ok1 && ok2 && ok3)) begin n_bad++; $display("FAIL b2b_complete got=%b%b%b exp=111", ok1, ok2, ok3); end
    n_cmp++; if (b1[9:0] !== 10'h2AA) begin n_bad++; $display("FAIL b2b_bits_55 got=%h exp=2aa", b1[9:0]); end
    n_cmp++; if (b2[9:0] !== 10'h21E) begin n_bad++; $display("FAIL b2b_bits_0f got=%h exp=21e", b2[9:0]); end
    n_cmp++; if (b3[9:0] !== 10'h3FE) begin n_bad++; $display("FAIL b2b_bits_ff got=%h exp=3fe", b3[9:0]); end
    n_cmp++; if (f2 - d1 - 1 !== 1) begin n_bad++; $display("FAIL b2b_gap12 got=%0d exp=1", f2 - d1 - 1); end
    n_cmp++; if (f3 - d2 - 1 !== 1) begin n_bad++; $display("FAIL b2b_gap23 got=%0d exp=1", f3 - d2 - 1); end
    repeat (100) @(negedge clk);
    n_cmp++; if (pop_cnt - p0 !== 3) begin n_bad++; $display("FAIL b2b_pops got=%0d exp=3", pop_cnt - p0); end
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy_s); end
  endtask

  task automatic test_parity;
    logic [15:0] bits;
    int f, d, r;
    bit ok;
    sel = 2'd1;
    load_aligned(8'h07);
    capture_frame(11, bits, f, d, r, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL even_complete got=timeout exp=done"); end
    n_cmp++; if (bits[10:0] !== 11'h60E) begin n_bad++; $display("FAIL even_bits got=%h exp=60e", bits[10:0]); end
    n_cmp++; if (d - f + 1 !== 704) begin n_bad++; $display("FAIL even_length got=%0d exp=704", d - f + 1); end
    repeat (10) @(negedge clk);
    sel = 2'd2;
    load_aligned(8'h07);
    capture_frame(11, bits, f, d, r, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL odd_complete got=timeout exp=done"); end
    n_cmp++; if (bits[10:0] !== 11'h40E) begin n_bad++; $display("FAIL odd_bits got=%h exp=40e", bits[10:0]); end
    n_cmp++; if (d - f + 1 !== 704) begin n_bad++; $display("FAIL odd_length got=%0d exp=704", d - f + 1); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_stop_32;
    logic [15:0] bits;
    int f, d, r;
    bit ok;
    sel = 2'd3;
    load_aligned(8'h00);
    capture_frame(10, bits, f, d, r, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sb32_complete got=timeout exp=done"); end
    n_cmp++; if (bits[9:0] !== 10'h200) begin n_bad++; $display("FAIL sb32_bits got=%h exp=200", bits[9:0]); end
    n_cmp++; if (d - r + 1 !== 128) begin n_bad++; $display("FAIL sb32_stop_len got=%0d exp=128", d - r + 1); end
    n_cmp++; if (d - f + 1 !== 704) begin n_bad++; $display("FAIL sb32_length got=%0d exp=704", d - f + 1); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int waited, f, p0, lows;
    sel = 2'd0;
    load_aligned(8'h3C);
    waited = 0;
    @(negedge clk);
    while (tx_s !== 1'b0 && waited < 100) begin @(negedge clk); waited++; end
    n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL midrst_start got=%b exp=0 (timeout)", tx_s); end
    f = int'(cyc);
    while (int'(cyc) - f < 288) @(negedge clk);
    n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL midrst_bit3 got=%b exp=1", tx_s); end
    n_cmp++; if (busy_s !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy_s); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL midrst_tx got=%b exp=1", tx_s); end
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", busy_s); end
    repeat (3) @(negedge clk);
    p0 = pop_cnt;
    reset_n = 1'b1;
    lows = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx_s !== 1'b1) lows++;
    end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL midrst_tx_idle got=%0d low cycles exp=0", lows); end
    n_cmp++; if (pop_cnt - p0 !== 0) begin n_bad++; $display("FAIL midrst_pops got=%0d exp=0", pop_cnt - p0); end
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL midrst_idle_busy got=%b exp=0", busy_s); end
  endtask

  task automatic test_rd_guard;
    n_cmp++; if (bad_rd !== 0) begin n_bad++; $display("FAIL rd_while_empty got=%0d exp=0", bad_rd); end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset;
    test_frame_a5;
    test_back_to_back;
    test_parity;
    test_stop_32;
    test_reset_mid_frame;
    test_rd_guard;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
